// File: rtl/fb_write_arbiter.sv
// Round-robin collector of engine pixel results feeding the framebuffer write port.
// Optional FB_WRITE_BOUNDS_CHECK_EN drops off-frame results and adds the drop_count output.
module fb_write_arbiter #(
  parameter int NUM_ENGINES = 4,
  parameter int WIDTH       = 512,
  parameter int HEIGHT      = 384,
  parameter int DIM_BITS    = 9,
  parameter int DATA_BITS   = 4,
  parameter int ITER_BITS   = 16
) (
  input  logic                             clk_calc,
  input  logic                             rst_n,
  input  logic [NUM_ENGINES-1:0]           eng_valid,
  output logic [NUM_ENGINES-1:0]           eng_ready,
  input  logic [NUM_ENGINES*DIM_BITS-1:0]  eng_x,
  input  logic [NUM_ENGINES*DIM_BITS-1:0]  eng_y,
  input  logic [NUM_ENGINES*ITER_BITS-1:0] eng_iter,
  input  logic [ITER_BITS-1:0]             max_iter,
  input  logic                             frame_start,
  output logic                             wr_en,
  output logic [2*DIM_BITS-1:0]            wr_addr,
  output logic [DATA_BITS-1:0]             wr_data,
  output logic [19:0]                      pixel_count,
  output logic                             frame_done
`ifdef FB_WRITE_BOUNDS_CHECK_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int          PTR_BITS     = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [19:0] FRAME_PIXELS = 20'(WIDTH * HEIGHT);

  logic [DIM_BITS-1:0]  x_arr    [NUM_ENGINES];
  logic [DIM_BITS-1:0]  y_arr    [NUM_ENGINES];
  logic [ITER_BITS-1:0] iter_arr [NUM_ENGINES];

  logic [PTR_BITS-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [PTR_BITS-1:0]  grant_idx;
  logic [PTR_BITS-1:0]  cand_idx;
  logic                 grant_any;

  logic                 s1_valid_reg;
  logic [DIM_BITS-1:0]  s1_x_reg, s1_y_reg;
  logic [ITER_BITS-1:0] s1_iter_reg;

  logic                 in_bounds;
  logic [DATA_BITS-1:0] colour;

  logic                 wr_en_reg;
  logic [2*DIM_BITS-1:0] wr_addr_reg;
  logic [DATA_BITS-1:0] wr_data_reg;
  logic [19:0]          pixel_count_reg;
  logic                 frame_done_reg;

  generate
    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
      assign x_arr[gi]     = eng_x[gi*DIM_BITS +: DIM_BITS];
      assign y_arr[gi]     = eng_y[gi*DIM_BITS +: DIM_BITS];
      assign iter_arr[gi]  = eng_iter[gi*ITER_BITS +: ITER_BITS];
      assign eng_ready[gi] = grant_any && (grant_idx == PTR_BITS'(gi));
    end
  endgenerate

  // Scan from the farthest candidate back to rr_ptr so the nearest valid engine wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      cand_idx = PTR_BITS'((int'(rr_ptr_reg) + k) % NUM_ENGINES);
      if (eng_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    if (!grant_any)
      rr_ptr_next = rr_ptr_reg;
    else if (grant_idx == PTR_BITS'(NUM_ENGINES - 1))
      rr_ptr_next = '0;
    else
      rr_ptr_next = grant_idx + PTR_BITS'(1);
  end

  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
      s1_iter_reg  <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      s1_valid_reg <= grant_any;
      if (grant_any) begin
        s1_x_reg    <= x_arr[grant_idx];
        s1_y_reg    <= y_arr[grant_idx];
        s1_iter_reg <= iter_arr[grant_idx];
      end
    end
  end

  // Index 0 is reserved for points inside the set.
  always_comb begin
    if (s1_iter_reg >= max_iter)
      colour = '0;
    else if (s1_iter_reg[DATA_BITS-1:0] == '0)
      colour = '1;
    else
      colour = s1_iter_reg[DATA_BITS-1:0];
  end

`ifdef FB_WRITE_BOUNDS_CHECK_EN
  localparam logic [DIM_BITS:0] X_LIMIT = (DIM_BITS+1)'(WIDTH);
  localparam logic [DIM_BITS:0] Y_LIMIT = (DIM_BITS+1)'(HEIGHT);
  logic [15:0] drop_count_reg;

  assign in_bounds = ({1'b0, s1_x_reg} < X_LIMIT) && ({1'b0, s1_y_reg} < Y_LIMIT);

  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n)
      drop_count_reg <= '0;
    else if (frame_start)
      drop_count_reg <= '0;
    else if (s1_valid_reg && !in_bounds && drop_count_reg != 16'hFFFF)
      drop_count_reg <= drop_count_reg + 16'd1;
  end

  assign drop_count = drop_count_reg;
`else
  assign in_bounds = 1'b1;
`endif

  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= s1_valid_reg && in_bounds;
      if (s1_valid_reg && in_bounds) begin
        wr_addr_reg <= {s1_y_reg, s1_x_reg};
        wr_data_reg <= colour;
      end
    end
  end

  // Count saturates at the frame size, so frame_done fires once per frame.
  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      pixel_count_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else if (frame_start) begin
      pixel_count_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else if (wr_en_reg && pixel_count_reg != FRAME_PIXELS) begin
      pixel_count_reg <= pixel_count_reg + 20'd1;
      frame_done_reg  <= (pixel_count_reg + 20'd1 == FRAME_PIXELS);
    end else begin
      frame_done_reg  <= 1'b0;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign pixel_count = pixel_count_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed pins plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
  localparam int N = 4, W = 4, H = 2, DB = 9, DAT = 4, IB = 16;
  localparam int TOTAL = W * H;

  logic              clk_calc = 1'b0;
  logic              rst_n;
  logic [N-1:0]      eng_valid, eng_ready;
  logic [N*DB-1:0]   eng_x, eng_y;
  logic [N*IB-1:0]   eng_iter;
  logic [IB-1:0]     max_iter;
  logic              frame_start, wr_en, frame_done;
  logic [2*DB-1:0]   wr_addr;
  logic [DAT-1:0]    wr_data;
  logic [19:0]       pixel_count;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
  logic [15:0]       drop_count;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  fb_write_arbiter #(
    .NUM_ENGINES(N), .WIDTH(W), .HEIGHT(H),
    .DIM_BITS(DB), .DATA_BITS(DAT), .ITER_BITS(IB)
  ) dut (
    .clk_calc(clk_calc), .rst_n(rst_n),
    .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_x(eng_x), .eng_y(eng_y), .eng_iter(eng_iter),
    .max_iter(max_iter), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pixel_count(pixel_count), .frame_done(frame_done)
`ifdef FB_WRITE_BOUNDS_CHECK_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk_calc = ~clk_calc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int x; int y; int iter; } pend_t;
  pend_t    pend[$];
  int       m_ptr, cyc, exp_count, exp_addr, exp_data;
  bit       exp_wr_en, exp_done;
  bit [N-1:0] m_taken;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
  int       exp_drop;
`endif

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N] === 1'b1) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int colour(input int it, input int mi);
    if (it >= mi) return 0;
    if (it % 16 == 0) return 15;
    return it % 16;
  endfunction

  always @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; cyc = 0; pend.delete();
      exp_wr_en = 0; exp_addr = 0; exp_data = 0;
      exp_count = 0; exp_done = 0; m_taken = '0;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
      exp_drop = 0;
`endif
    end else begin : mdl
      int g;
      bit drop;
      pend_t e;
      cyc++;
      drop = 1'b0;
      exp_done = 1'b0;
      if (frame_start) exp_count = 0;
      else if (exp_wr_en && exp_count < TOTAL) begin
        exp_count++;
        exp_done = (exp_count == TOTAL);
      end
      exp_wr_en = 1'b0;
      m_taken = '0;
      g = pick(eng_valid, m_ptr);
      if (g >= 0) begin
        e.due  = cyc + 1;
        e.x    = int'(eng_x[g*DB +: DB]);
        e.y    = int'(eng_y[g*DB +: DB]);
        e.iter = int'(eng_iter[g*IB +: IB]);
        pend.push_back(e);
        m_taken[g] = 1'b1;
        m_ptr = (g + 1) % N;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
`ifdef FB_WRITE_BOUNDS_CHECK_EN
        drop = (e.x >= W) || (e.y >= H);
`endif
        if (!drop) begin
          exp_wr_en = 1'b1;
          exp_addr  = e.y * (1 << DB) + e.x;
          exp_data  = colour(e.iter, int'(max_iter));
        end
      end
`ifdef FB_WRITE_BOUNDS_CHECK_EN
      if (frame_start) exp_drop = 0;
      else if (drop && exp_drop < 65535) exp_drop++;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_calc) begin
    if (chk_en) begin : cmp
      int g;
      g = pick(eng_valid, m_ptr);
      check("eng_ready", eng_ready, (g >= 0) ? (1 << g) : 0);
      check("wr_en", wr_en, exp_wr_en);
      if (exp_wr_en) begin
        check("wr_addr", wr_addr, exp_addr);
        check("wr_data", wr_data, exp_data);
      end
      check("pixel_count", pixel_count, exp_count);
      check("frame_done", frame_done, exp_done);
`ifdef FB_WRITE_BOUNDS_CHECK_EN
      check("drop_count", drop_count, exp_drop);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_calc);
    #1;
  endtask

  task automatic set_eng(input int i, input int x, input int y, input int it);
    eng_x[i*DB +: DB]    = DB'(x);
    eng_y[i*DB +: DB]    = DB'(y);
    eng_iter[i*IB +: IB] = IB'(it);
  endtask

  task automatic send_one(input int eng, input int x, input int y, input int it,
                          input int exp, input bit fs);
    set_eng(eng, x, y, it);
    eng_valid[eng] = 1'b1;
    tick();
    eng_valid[eng] = 1'b0;
    tick();
    #1;
    check("send_wr_en", wr_en, 1);
    check("send_wr_data", wr_data, exp);
    frame_start = fs;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; eng_valid = '0; eng_x = '0; eng_y = '0; eng_iter = '0;
    max_iter = 16'd64; frame_start = 1'b0;
    repeat (3) @(posedge clk_calc);
    #1;
    chk_en = 1'b1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_eng_ready", eng_ready, 0);
    rst_n = 1'b1;
    tick();

    // single pixel from engine 2
    set_eng(2, 5, 3, 7);
    eng_valid[2] = 1'b1;
    #1;
    check("single_ready", eng_ready, 4'b0100);
    tick();
    eng_valid[2] = 1'b0;
    tick();
    #1;
    check("single_wr_en", wr_en, 1);
    check("single_wr_addr", wr_addr, {9'd3, 9'd5});
    check("single_wr_data", wr_data, 7);
    tick();
    #1;
    check("single_one_strobe", wr_en, 0);
    check("single_count", pixel_count, 1);

    // reset one cycle after a transfer
    tick();
    set_eng(1, 1, 1, 9);
    eng_valid[1] = 1'b1;
    tick();
    eng_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_wr_en_a", wr_en, 0);
    tick();
    #1;
    check("rstmid_wr_en_b", wr_en, 0);
    check("rstmid_wr_addr", wr_addr, 0);
    check("rstmid_wr_data", wr_data, 0);
    check("rstmid_count", pixel_count, 0);
    check("rstmid_done", frame_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fairness: all engines valid for 8 grants, which also completes the 8-pixel frame
    for (int i = 0; i < N; i++) set_eng(i, i, 0, 20 + i);
    eng_valid = '1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) eng_valid = '0;
      #1;
      if (k < 8) check("fair_grant", eng_ready, 1 << (k % 4));
      if (k >= 2 && k <= 9) begin
        check("fair_wr_en", wr_en, 1);
        check("fair_x", wr_addr[DB-1:0], (k - 2) % 4);
      end
      if (k == 10) begin
        check("frame_done_pulse", frame_done, 1);
        check("frame_count", pixel_count, 8);
      end
      if (k == 11) check("frame_done_once", frame_done, 0);
      tick();
    end

    // colour map; these writes land after the frame is already complete
    send_one(0, 1, 1, 64, 0, 1'b0);
    send_one(1, 2, 1, 16, 15, 1'b0);
    send_one(2, 3, 1, 17, 1, 1'b0);
    send_one(3, 0, 0, 63, 15, 1'b0);
    #1;
    check("sat_count", pixel_count, 8);

    // frame_start coincident with a write increment
    send_one(0, 1, 0, 5, 5, 1'b1);
    #1;
    check("fs_coincident_count", pixel_count, 0);

`ifdef FB_WRITE_BOUNDS_CHECK_EN
    set_eng(0, W, 0, 3);
    eng_valid[0] = 1'b1;
    #1;
    check("oob_ready", eng_ready[0], 1);
    tick();
    eng_valid[0] = 1'b0;
    tick();
    #1;
    check("oob_no_wr", wr_en, 0);
    check("oob_drop", drop_count, 1);
    check("oob_count", pixel_count, 0);
`endif
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int load, x, y, it;
      load = (c < 2000) ? 35 : 90;
      for (int i = 0; i < N; i++) begin
        if (!(eng_valid[i] && !m_taken[i])) begin
          if ($urandom_range(0, 99) < load) begin
`ifdef FB_WRITE_BOUNDS_CHECK_EN
            x = $urandom_range(0, W + 1);
            y = $urandom_range(0, H);
`else
            x = $urandom_range(0, 511);
            y = $urandom_range(0, 511);
`endif
            it = $urandom_range(0, 300);
            set_eng(i, x, y, it);
            eng_valid[i] = 1'b1;
          end else begin
            eng_valid[i] = 1'b0;
          end
        end
      end
      frame_start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 249) == 0) max_iter = IB'($urandom_range(0, 300));
      if (c == 3000) rst_n = 1'b0;
      if (c == 3002) rst_n = 1'b1;
      tick();
    end
    eng_valid = '0;
    frame_start = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
